framebuffer_readback: RTL
=========================

# framebuffer_readback

Reads one 128-byte row of the framebuffer through its 8-bit port and streams it to the host over a UART TX line. It runs as a readback frame: header, row index, data, checksum. It is the transmit-side counterpart to the control module's UART row-write path and sits on the `clk_root` domain beside it. The host uses it to verify uploaded image data byte-for-byte.

## Interface
Parameters:
- `UART_TICKS_PER_BIT`, 434: clk_in cycles per UART bit.
- `UART_TICKS_PER_BIT_SIZE`, 9: width of the bit-tick counter.
- `BYTES_PER_ROW`, 128: data bytes per row (64 px × RGB565).
- `ROW_WIDTH`, 5: row index width (32 rows).
- `RAM_ADDR_WIDTH`, 12: framebuffer byte address width.
- `HEADER_BYTE`, 8'h52 ("R"): first byte of every frame.

Ports:
- `clk_in`, in, 1: the block's single clock.
- `reset`, in, 1: asynchronous, active-low reset (not the design's usual active-high; synchronize its release at the instantiation).
- `start`, in, 1: request a readback; sampled on each clk_in rising edge.
- `row`, in, ROW_WIDTH: row to read; latched when `start` is accepted.
- `busy`, out, 1: high while a frame is in progress.
- `done`, out, 1: single-cycle pulse at the end of a frame.
- `ram_address`, out, RAM_ADDR_WIDTH: framebuffer byte address.
- `ram_clk_enable`, out, 1: read strobe to the RAM port.
- `ram_data_in`, in, 8: RAM read data; valid 1 cycle after the strobe.
- `tx_out`, out, 1: UART 8N1, LSB first, idles high.

## Operation
- Reset values (asserted asynchronously): `tx_out`=1, `busy`=0, `done`=0, `ram_clk_enable`=0, `ram_address`=0, checksum=0, state IDLE.
- `start` is accepted only when `busy`=0, including the `done` cycle. `start` while busy is ignored, with no queuing.
- On acceptance:
  - latch `row` into `row_q`;
  - clear the checksum;
  - `busy` rises on the next cycle.
- States:
  - IDLE: waits for an accepted `start`, then goes to HDR.
  - HDR: sends `HEADER_BYTE`, then goes to IDX.
  - IDX: sends {3'b0, row_q}, then goes to DATA.
  - DATA: sends `BYTES_PER_ROW` bytes, then goes to CSUM.
  - CSUM: sends the checksum, then goes to FIN.
  - FIN: pulses `done`, then returns to IDLE.
- Address of data byte i (0..BYTES_PER_ROW-1) = row_q·BYTES_PER_ROW + i, truncated to RAM_ADDR_WIDTH. Row 31 covers 0xF80..0xFFF.
- Prefetch:
  - The byte for position i+1 is fetched while byte i is being shifted.
  - `ram_clk_enable` is high for exactly one cycle per data byte, 128 strobes per frame.
  - The fetched byte is captured one cycle after the strobe.
  - `ram_address` holds its last value outside the strobes.
- Checksum = XOR of the IDX byte and all data bytes; `HEADER_BYTE` is excluded.
- Frame length = (3 + BYTES_PER_ROW) bytes = 131 bytes.

## Timing
- Each bit is held for exactly `UART_TICKS_PER_BIT` cycles. Per byte: start (0), d0..d7, stop (1) = 10 bit periods.
- Bytes are back-to-back: the next start bit begins on the cycle after the previous stop bit's last cycle. There are no idle gaps.
- Edge alignment:
  - The HDR start bit (`tx_out` falls) is 2 cycles after the `start` acceptance edge.
  - `busy` is high from 1 cycle after acceptance until `done`.
- Frame duration: 131·10·UART_TICKS_PER_BIT cycles (568,540 at the defaults).
- `done` is high in the cycle after the checksum stop bit ends, and `busy` is low in that same cycle.
- Reset mid-frame:
  - `tx_out` returns high immediately (asynchronously);
  - the frame is abandoned with no `done`;
  - the next frame starts cleanly.
- `row` changing while busy has no effect.

## Structure
- Shared package: the state encoding, HEADER_BYTE, and the frame-length constant (3 + BYTES_PER_ROW), for reuse by the host-side model and the bench.
- One sub-module, `readback_uart_tx`:
  - inputs: byte + `load`;
  - outputs: `ready` + `tx_out`;
  - contains the bit-tick counter and the 10-bit shift register;
  - `ready` is asserted on the final tick of the stop bit.
- Top level: FSM, byte counter (8 bits), address generation, prefetch register, checksum.

## Test plan
- Reset: hold `reset`=0 for 5 cycles → `tx_out`=1, `busy`=0, `done`=0, `ram_clk_enable`=0, `ram_address`=0.
- Row 3, RAM byte at 0x180+i = i (UART_TICKS_PER_BIT=4):
  - bench decodes 131 bytes: 0x52, 0x03, 0x00..0x7F, checksum 0x03;
  - addresses 0x180..0x1FF are each strobed exactly once;
  - `done` arrives exactly 5240 cycles after the first start-bit edge.
- Row 31, all bytes 0xFF: addresses 0xF80..0xFFF, no wrap past 0xFFF, checksum = 0x1F.
- `start` pulsed with row=5 mid-frame during a row-2 frame → no effect, the frame completes as row 2; `start` on the `done` cycle → a new frame starts 2 cycles later.
- Reset asserted during data byte 40 → `tx_out`=1 on the same edge and no `done`; a following row-7 request yields a correct complete frame.
- Inter-byte timing: measure every start-bit falling edge → spacing is exactly 10·UART_TICKS_PER_BIT cycles across all 131 bytes.

Source files
------------

// File: rtl/framebuffer_readback_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_readback_pkg
// Shared definitions for the row readback transmitter: frame state encoding,
// default header byte, default row length and the resulting frame length.
// Also used by the host-side model and the bench.
// -----------------------------------------------------------------------------
package framebuffer_readback_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_IDX  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam logic [7:0] RB_HEADER_BYTE   = 8'h52;   // "R"
    localparam int         RB_BYTES_PER_ROW = 128;     // 64 px x RGB565
    localparam int         RB_FRAME_BYTES   = 3 + RB_BYTES_PER_ROW;

    // Frame length for an arbitrary row length: header + index + data + checksum
    function automatic int frame_bytes(input int bytes_per_row);
        return 3 + bytes_per_row;
    endfunction

endpackage

// File: rtl/readback_uart_tx.sv
// -----------------------------------------------------------------------------
// readback_uart_tx
// 8N1 UART transmitter, LSB first, idle high. A byte presented with `load`
// is framed as start(0), d0..d7, stop(1), each bit held TICKS cycles.
// `ready` is high on the final tick of the stop bit so the next byte can be
// loaded on that same edge with no idle gap. The line output is registered,
// so it trails the internal shift register by one cycle.
//
// Ports:
//   clk_in  in  1  clock
//   reset   in  1  asynchronous active-low reset
//   data    in  8  byte to send, sampled when load=1
//   load    in  1  start sending `data` (overrides any byte in flight)
//   ready   out 1  final tick of the stop bit
//   tx_out  out 1  serial line
// -----------------------------------------------------------------------------
module readback_uart_tx #(
    parameter int TICKS  = 434,
    parameter int TICK_W = 9
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       tx_out
);

    logic [9:0]        shift_r;
    logic [TICK_W-1:0] tick_r;
    logic [3:0]        bit_r;
    logic              active_r;
    logic              tx_r;
    logic              last_tick_s;

    assign last_tick_s = active_r && (tick_r == TICK_W'(TICKS - 1));
    assign ready       = last_tick_s && (bit_r == 4'd9);
    assign tx_out      = tx_r;

    // Bit timing and shift register; a load restarts the frame at the start bit
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            shift_r  <= 10'h3FF;
            tick_r   <= '0;
            bit_r    <= 4'd0;
            active_r <= 1'b0;
        end else if (load) begin
            shift_r  <= {1'b1, data, 1'b0};
            tick_r   <= '0;
            bit_r    <= 4'd0;
            active_r <= 1'b1;
        end else if (active_r) begin
            if (last_tick_s) begin
                tick_r  <= '0;
                shift_r <= {1'b1, shift_r[9:1]};
                bit_r   <= bit_r + 4'd1;
                if (bit_r == 4'd9) begin
                    active_r <= 1'b0;
                end
            end else begin
                tick_r <= tick_r + TICK_W'(1);
            end
        end
    end

    // Registered line driver; idles high and returns high on reset
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tx_r <= 1'b1;
        end else begin
            tx_r <= active_r ? shift_r[0] : 1'b1;
        end
    end

endmodule

// File: rtl/framebuffer_readback.sv
// -----------------------------------------------------------------------------
// framebuffer_readback
// Reads one framebuffer row through the 8-bit RAM port and sends it over
// UART as: header, row index, BYTES_PER_ROW data bytes, checksum (XOR of the
// index byte and all data bytes). Data bytes are prefetched one byte ahead so
// bytes go out back-to-back.
//
// Ports:
//   clk_in          in  1               clock
//   reset           in  1               asynchronous active-low reset
//   start           in  1               readback request (accepted when idle)
//   row             in  ROW_WIDTH       row to read, latched on acceptance
//   busy            out 1               frame in progress
//   done            out 1               one-cycle pulse after the checksum
//   ram_address     out RAM_ADDR_WIDTH  framebuffer byte address
//   ram_clk_enable  out 1               read strobe, one cycle per data byte
//   ram_data_in     in  8               read data, valid 1 cycle after strobe
//   tx_out          out 1               UART 8N1 line
// -----------------------------------------------------------------------------
module framebuffer_readback #(
    parameter int         UART_TICKS_PER_BIT      = 434,
    parameter int         UART_TICKS_PER_BIT_SIZE = 9,
    parameter int         BYTES_PER_ROW           = framebuffer_readback_pkg::RB_BYTES_PER_ROW,
    parameter int         ROW_WIDTH               = 5,
    parameter int         RAM_ADDR_WIDTH          = 12,
    parameter logic [7:0] HEADER_BYTE             = framebuffer_readback_pkg::RB_HEADER_BYTE
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ROW_WIDTH-1:0]      row,
    output logic                      busy,
    output logic                      done,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic                      ram_clk_enable,
    input  logic [7:0]                ram_data_in,
    output logic                      tx_out
);

    import framebuffer_readback_pkg::*;

    localparam logic [7:0] LAST_CNT = 8'(BYTES_PER_ROW);

    state_t                    state_r;
    state_t                    state_next_s;
    logic [ROW_WIDTH-1:0]      row_r;
    logic [7:0]                byte_cnt_r;     // data bytes handed to the UART
    logic [7:0]                csum_r;
    logic [7:0]                pref_r;         // next data byte, fetched ahead
    logic                      hdr_loaded_r;   // header already in the UART
    logic                      fetch_pend_r;   // RAM data arrives this cycle
    logic                      busy_r;
    logic                      done_r;
    logic                      ram_clk_enable_r;
    logic [RAM_ADDR_WIDTH-1:0] ram_address_r;

    logic                      load_s;
    logic [7:0]                tx_byte_s;
    logic                      accept_s;
    logic                      fetch_s;
    logic [7:0]                fetch_idx_s;
    logic                      csum_add_s;
    logic                      cnt_inc_s;
    logic                      ready_s;
    logic [RAM_ADDR_WIDTH-1:0] fetch_addr_s;

    assign busy           = busy_r;
    assign done           = done_r;
    assign ram_clk_enable = ram_clk_enable_r;
    assign ram_address    = ram_address_r;

    // row*BYTES_PER_ROW + index, truncated to the RAM address width
    assign fetch_addr_s = RAM_ADDR_WIDTH'(32'(row_r) * 32'(BYTES_PER_ROW) + 32'(fetch_idx_s));

    readback_uart_tx #(
        .TICKS  (UART_TICKS_PER_BIT),
        .TICK_W (UART_TICKS_PER_BIT_SIZE)
    ) u_tx (
        .clk_in (clk_in),
        .reset  (reset),
        .data   (tx_byte_s),
        .load   (load_s),
        .ready  (ready_s),
        .tx_out (tx_out)
    );

    // Next-state, UART load and RAM fetch decisions
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        tx_byte_s    = 8'h00;
        accept_s     = 1'b0;
        fetch_s      = 1'b0;
        fetch_idx_s  = 8'h00;
        csum_add_s   = 1'b0;
        cnt_inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                // The header is loaded one cycle after acceptance, which puts
                // the first start bit two cycles after the accepting edge.
                if (!hdr_loaded_r) begin
                    load_s    = 1'b1;
                    tx_byte_s = HEADER_BYTE;
                end else if (ready_s) begin
                    load_s       = 1'b1;
                    tx_byte_s    = 8'(row_r);
                    csum_add_s   = 1'b1;
                    fetch_s      = 1'b1;
                    fetch_idx_s  = 8'h00;
                    state_next_s = ST_IDX;
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_IDX, ST_DATA: begin
                if (ready_s) begin
                    if (byte_cnt_r == LAST_CNT) begin
                        load_s       = 1'b1;
                        tx_byte_s    = csum_r;
                        state_next_s = ST_CSUM;
                    end else begin
                        load_s       = 1'b1;
                        tx_byte_s    = pref_r;
                        csum_add_s   = 1'b1;
                        cnt_inc_s    = 1'b1;
                        state_next_s = ST_DATA;
                        // Fetch the byte after the one just loaded, if any
                        if ((byte_cnt_r + 8'd1) < LAST_CNT) begin
                            fetch_s     = 1'b1;
                            fetch_idx_s = byte_cnt_r + 8'd1;
                        end else begin
                            fetch_s = 1'b0;
                        end
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_CSUM: begin
                if (ready_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_CSUM;
                end
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            hdr_loaded_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            done_r       <= (state_r == ST_FIN);
            hdr_loaded_r <= (state_r == ST_HDR);
        end
    end

    // Row latch, checksum accumulation and data byte counter
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            row_r      <= '0;
            csum_r     <= 8'h00;
            byte_cnt_r <= 8'h00;
        end else if (accept_s) begin
            row_r      <= row;
            csum_r     <= 8'h00;
            byte_cnt_r <= 8'h00;
        end else begin
            if (csum_add_s) begin
                csum_r <= csum_r ^ tx_byte_s;
            end
            if (cnt_inc_s) begin
                byte_cnt_r <= byte_cnt_r + 8'd1;
            end
        end
    end

    // RAM strobe/address generation and prefetch capture; the address holds
    // its last value between strobes
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            ram_clk_enable_r <= 1'b0;
            ram_address_r    <= '0;
            fetch_pend_r     <= 1'b0;
            pref_r           <= 8'h00;
        end else begin
            ram_clk_enable_r <= fetch_s;
            if (fetch_s) begin
                ram_address_r <= fetch_addr_s;
            end
            fetch_pend_r <= ram_clk_enable_r;
            if (fetch_pend_r) begin
                pref_r <= ram_data_in;
            end
        end
    end

endmodule
